// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, funct, ALU encoding and control-state definitions
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_LW  = 2'd1,
        CLS_SW  = 2'd2,
        CLS_BEQ = 2'd3
    } inst_cls_e;

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - combinational opcode/funct to ALUcontrol, instruction class and legal flag
module mips_alu_decode
    import mips_pkg::*;
#(
    parameter bit BEQ_EN = 1'b0
) (
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output inst_cls_e  cls_o,
    output logic       legal_o
);

    // Illegal encodings leave ALUcontrol at zero so callers can forward it unmasked.
    always_comb begin
        alu_ctrl_o = 4'b0000;
        cls_o      = CLS_R;
        legal_o    = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: begin alu_ctrl_o = ALU_ADD; legal_o = 1'b1; end
                    FUNCT_SUB: begin alu_ctrl_o = ALU_SUB; legal_o = 1'b1; end
                    FUNCT_AND: begin alu_ctrl_o = ALU_AND; legal_o = 1'b1; end
                    FUNCT_OR:  begin alu_ctrl_o = ALU_OR;  legal_o = 1'b1; end
                    FUNCT_SLT: begin alu_ctrl_o = ALU_SLT; legal_o = 1'b1; end
                    default: ;
                endcase
            end
            OP_LW: begin
                alu_ctrl_o = ALU_ADD;
                cls_o      = CLS_LW;
                legal_o    = 1'b1;
            end
            OP_SW: begin
                alu_ctrl_o = ALU_ADD;
                cls_o      = CLS_SW;
                legal_o    = 1'b1;
            end
            OP_BEQ: begin
                if (BEQ_EN) begin
                    alu_ctrl_o = ALU_SUB;
                    cls_o      = CLS_BEQ;
                    legal_o    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle MIPS control sequencer; MIPS_MC_BEQ_EN adds beq with Branch/branch_taken
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int INST_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] inst_in,
    input  logic              inst_valid,
`ifdef MIPS_MC_BEQ_EN
    input  logic              alu_zero,
    output logic              Branch,
    output logic              branch_taken,
`endif
    output logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrc,
    output logic [3:0]        ALUcontrol,
    output logic              MemWrite,
    output logic              MemRead,
    output logic              MemToReg,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

`ifdef MIPS_MC_BEQ_EN
    localparam bit BEQ_EN = 1'b1;
`else
    localparam bit BEQ_EN = 1'b0;
`endif

    localparam int MC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [MC_W-1:0] MEM_LOAD = MC_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    inst_cls_e         cls_q;
    logic [INST_W-1:0] inst_q;
    logic              reg_dst_q, reg_write_q, alu_src_q, mem_write_q;
    logic              mem_read_q, mem_to_reg_q, illegal_q;
    logic [3:0]        alu_ctrl_q;
    logic [MC_W-1:0]   mem_cnt_q;
    logic [CNT_W-1:0]  retired_q;
    logic              retire;

    logic [3:0]        dec_alu;
    inst_cls_e         dec_cls;
    logic              dec_legal;

    mips_alu_decode #(
        .BEQ_EN (BEQ_EN)
    ) u_alu_decode (
        .op_i       (inst_q[INST_W-1 -: 6]),
        .funct_i    (inst_q[5:0]),
        .alu_ctrl_o (dec_alu),
        .cls_o      (dec_cls),
        .legal_o    (dec_legal)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH:  if (inst_valid) state_d = DECODE;
            DECODE: state_d = dec_legal ? EXEC : FETCH;
            EXEC: begin
                case (cls_q)
                    CLS_LW, CLS_SW: state_d = MEM;
                    CLS_BEQ: begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                if (mem_cnt_q == '0) begin
                    if (cls_q == CLS_SW) begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

`ifdef MIPS_MC_BEQ_EN
    logic branch_q;
`endif

    // Strobes are registered from state_d so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            cls_q        <= CLS_R;
            inst_q       <= '0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= 4'b0000;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            illegal_q    <= 1'b0;
            mem_cnt_q    <= '0;
            retired_q    <= '0;
`ifdef MIPS_MC_BEQ_EN
            branch_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && inst_valid) begin
                inst_q <= inst_in;
            end
            if (state_q == DECODE) begin
                cls_q        <= dec_cls;
                reg_dst_q    <= dec_legal && (dec_cls == CLS_R);
                alu_src_q    <= dec_legal && (dec_cls == CLS_LW || dec_cls == CLS_SW);
                alu_ctrl_q   <= dec_alu;
                mem_to_reg_q <= dec_legal && (dec_cls == CLS_LW);
            end
            illegal_q   <= (state_q == DECODE) && !dec_legal;
            reg_write_q <= (state_d == WB);
            mem_read_q  <= (state_d == MEM) && (cls_q == CLS_LW);
            mem_write_q <= (state_d == MEM) && (cls_q == CLS_SW);
            if (state_q == EXEC && state_d == MEM) begin
                mem_cnt_q <= MEM_LOAD;
            end else if (state_q == MEM && mem_cnt_q != '0) begin
                mem_cnt_q <= mem_cnt_q - 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
`ifdef MIPS_MC_BEQ_EN
            branch_q <= (state_d == EXEC) && (dec_cls == CLS_BEQ);
`endif
        end
    end

    assign inst_ready = (state_q == FETCH);
    assign inst       = inst_q;
    assign RegDst     = reg_dst_q;
    assign RegWrite   = reg_write_q;
    assign ALUSrc     = alu_src_q;
    assign ALUcontrol = alu_ctrl_q;
    assign MemWrite   = mem_write_q;
    assign MemRead    = mem_read_q;
    assign MemToReg   = mem_to_reg_q;
    assign illegal    = illegal_q;
    assign retired    = retired_q;
`ifdef MIPS_MC_BEQ_EN
    assign Branch       = branch_q;
    assign branch_taken = branch_q && alu_zero;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for mips_mc_control (MEM_LAT=1 and MEM_LAT=3/CNT_W=2)
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        valid;
    logic [31:0] in_w;

    always #5 clk = ~clk;

    logic        a_ready, a_rd, a_rw, a_as, a_mw, a_mr, a_m2r, a_ill;
    logic [31:0] a_inst;
    logic [3:0]  a_aluc;
    logic [15:0] a_ret;
    logic        b_ready, b_rd, b_rw, b_as, b_mw, b_mr, b_m2r, b_ill;
    logic [31:0] b_inst;
    logic [3:0]  b_aluc;
    logic [1:0]  b_ret;
`ifdef MIPS_MC_BEQ_EN
    logic a_zero = 1'b0;
    logic b_zero = 1'b0;
    logic a_br, a_bt, b_br, b_bt;
`endif

    mips_mc_control dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_in    (in_w),
        .inst_valid (valid & ~sel),
`ifdef MIPS_MC_BEQ_EN
        .alu_zero     (a_zero),
        .Branch       (a_br),
        .branch_taken (a_bt),
`endif
        .inst_ready (a_ready),
        .inst       (a_inst),
        .RegDst     (a_rd),
        .RegWrite   (a_rw),
        .ALUSrc     (a_as),
        .ALUcontrol (a_aluc),
        .MemWrite   (a_mw),
        .MemRead    (a_mr),
        .MemToReg   (a_m2r),
        .illegal    (a_ill),
        .retired    (a_ret)
    );

    mips_mc_control #(.INST_W(32), .MEM_LAT(3), .CNT_W(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_in    (in_w),
        .inst_valid (valid & sel),
`ifdef MIPS_MC_BEQ_EN
        .alu_zero     (b_zero),
        .Branch       (b_br),
        .branch_taken (b_bt),
`endif
        .inst_ready (b_ready),
        .inst       (b_inst),
        .RegDst     (b_rd),
        .RegWrite   (b_rw),
        .ALUSrc     (b_as),
        .ALUcontrol (b_aluc),
        .MemWrite   (b_mw),
        .MemRead    (b_mr),
        .MemToReg   (b_m2r),
        .illegal    (b_ill),
        .retired    (b_ret)
    );

    logic        o_ready, o_rd, o_rw, o_as, o_mw, o_mr, o_m2r, o_ill;
    logic [31:0] o_inst;
    logic [3:0]  o_aluc;
    logic [15:0] o_ret;

    assign o_ready = sel ? b_ready : a_ready;
    assign o_rd    = sel ? b_rd    : a_rd;
    assign o_rw    = sel ? b_rw    : a_rw;
    assign o_as    = sel ? b_as    : a_as;
    assign o_mw    = sel ? b_mw    : a_mw;
    assign o_mr    = sel ? b_mr    : a_mr;
    assign o_m2r   = sel ? b_m2r   : a_m2r;
    assign o_ill   = sel ? b_ill   : a_ill;
    assign o_inst  = sel ? b_inst  : a_inst;
    assign o_aluc  = sel ? b_aluc  : a_aluc;
    assign o_ret   = sel ? {14'b0, b_ret} : a_ret;

    int errors = 0;
    int checks = 0;
    int lat, n_rw, n_mr, n_mw, n_ill, first_rw, first_mr, first_mw, first_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and trace strobes until inst_ready returns (bounded).
    task automatic run(input logic [31:0] instr, input bit hold);
        in_w  = instr;
        valid = 1'b1;
        for (int w = 0; w < 20 && !o_ready; w++) step();
        step();
        lat = -1; n_rw = 0; n_mr = 0; n_mw = 0; n_ill = 0;
        first_rw = 0; first_mr = 0; first_mw = 0; first_ill = 0;
        for (int k = 1; k < 16; k++) begin
            if (o_rw)  begin n_rw++;  if (first_rw == 0)  first_rw = k;  end
            if (o_mr)  begin n_mr++;  if (first_mr == 0)  first_mr = k;  end
            if (o_mw)  begin n_mw++;  if (first_mw == 0)  first_mw = k;  end
            if (o_ill) begin n_ill++; if (first_ill == 0) first_ill = k; end
            if (o_ready) begin
                lat = k - 1;
                break;
            end
            step();
        end
        if (!hold) valid = 1'b0;
    endtask

    logic [31:0] b2b_inst [5];
    logic [3:0]  b2b_aluc [5];

    initial begin
        b2b_inst[0] = 32'h0043_0820; b2b_aluc[0] = 4'b0010;
        b2b_inst[1] = 32'h0043_0822; b2b_aluc[1] = 4'b0110;
        b2b_inst[2] = 32'h0043_0824; b2b_aluc[2] = 4'b0000;
        b2b_inst[3] = 32'h0043_0825; b2b_aluc[3] = 4'b0001;
        b2b_inst[4] = 32'h0043_082A; b2b_aluc[4] = 4'b0111;

        rst_n = 1'b0; sel = 1'b0; valid = 1'b0; in_w = 32'h0;
        step();
        step();
        check("rst_inst",  o_inst, 32'h0);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_strobes", {29'b0, o_rw, o_mr, o_mw}, 32'd0);
        check("rst_ctrl", {25'b0, o_rd, o_as, o_m2r, o_aluc}, 32'd0);
        check("rst_illegal", {31'b0, o_ill}, 32'd0);
        check("rst_retired", {16'b0, o_ret}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // add $1,$2,$3 on MEM_LAT=1
        run(32'h0043_0820, 1'b0);
        check("add_inst",     o_inst, 32'h0043_0820);
        check("add_latency",  32'(lat), 32'd3);
        check("add_rw_cycle", 32'(first_rw), 32'd3);
        check("add_rw_count", 32'(n_rw), 32'd1);
        check("add_mem_strobes", 32'(n_mr + n_mw), 32'd0);
        check("add_ctrl", {25'b0, o_rd, o_as, o_m2r, o_aluc}, {25'b0, 1'b1, 1'b0, 1'b0, 4'b0010});
        check("add_retired", {16'b0, o_ret}, 32'd1);

        // sw $1,0($2)
        run(32'hAC41_0000, 1'b0);
        check("sw_latency",  32'(lat), 32'd3);
        check("sw_mw_count", 32'(n_mw), 32'd1);
        check("sw_mw_cycle", 32'(first_mw), 32'd3);
        check("sw_rw_count", 32'(n_rw), 32'd0);
        check("sw_ctrl", {25'b0, o_rd, o_as, o_m2r, o_aluc}, {25'b0, 1'b0, 1'b1, 1'b0, 4'b0010});
        check("sw_retired", {16'b0, o_ret}, 32'd2);

        // j: unsupported
        run(32'h0800_0000, 1'b0);
        check("j_latency",   32'(lat), 32'd1);
        check("j_ill_count", 32'(n_ill), 32'd1);
        check("j_ill_cycle", 32'(first_ill), 32'd2);
        check("j_strobes",   32'(n_rw + n_mr + n_mw), 32'd0);
        check("j_ctrl", {25'b0, o_rd, o_as, o_m2r, o_aluc}, 32'd0);
        check("j_retired", {16'b0, o_ret}, 32'd2);
        step();
        check("j_ill_pulse_end", {31'b0, o_ill}, 32'd0);
        check("j_ready_idle", {31'b0, o_ready}, 32'd1);

        // lw $1,0($2) on MEM_LAT=3
        sel = 1'b1;
        run(32'h8C41_0000, 1'b0);
        check("lw_latency",  32'(lat), 32'd6);
        check("lw_mr_count", 32'(n_mr), 32'd3);
        check("lw_mr_cycle", 32'(first_mr), 32'd3);
        check("lw_rw_cycle", 32'(first_rw), 32'd6);
        check("lw_rw_count", 32'(n_rw), 32'd1);
        check("lw_ctrl", {25'b0, o_rd, o_as, o_m2r, o_aluc}, {25'b0, 1'b0, 1'b1, 1'b1, 4'b0010});
        check("lw_retired", {16'b0, o_ret}, 32'd1);

        // Asynchronous reset in the middle of a lw MEM phase
        in_w  = 32'h8C41_0000;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        step();
        check("mid_mem_read", {31'b0, o_mr}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_strobes", {29'b0, o_rw, o_mr, o_mw}, 32'd0);
        check("arst_ctrl", {25'b0, o_rd, o_as, o_m2r, o_aluc}, 32'd0);
        check("arst_inst", o_inst, 32'h0);
        check("arst_retired", {16'b0, o_ret}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_strobes", {29'b0, o_rw, o_mr, o_mw}, 32'd0);
        check("post_rst_ready", {31'b0, o_ready}, 32'd1);
        check("post_rst_retired", {16'b0, o_ret}, 32'd0);

        // Back-to-back R-type with valid held; retired is 2 bits wide
        for (int i = 0; i < 5; i++) begin
            run(b2b_inst[i], (i < 4));
            check($sformatf("b2b%0d_aluc", i), {28'b0, o_aluc}, {28'b0, b2b_aluc[i]});
            check($sformatf("b2b%0d_retired", i), {16'b0, o_ret}, 32'((i + 1) % 4));
            check($sformatf("b2b%0d_latency", i), 32'(lat), 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle control sequencer that sits directly upstream of the MIPS datapath.
- Accepts 32-bit instructions from the fetch stage over a valid/ready handshake and holds each one in an instruction register that drives the datapath `inst` input.
- Steps through FETCH/DECODE/EXEC/MEM/WB and drives RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead and MemToReg cycle by cycle.
- Replaces the hand-driven control stimulus with real sequencing.

Parameters:
- INST_W, 32: instruction width.
- MEM_LAT, 1: cycles spent in MEM (>=1); models data-memory wait.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inst_in  input  INST_W  instruction from fetch.
- inst_valid  input  1  inst_in valid.
- inst_ready  output  1  control accepts instruction (high only in FETCH).
- inst  output  INST_W  instruction register to datapath.
- RegDst  output  1  1 = rd, 0 = rt destination.
- RegWrite  output  1  register file write strobe.
- ALUSrc  output  1  1 = sign-extended imm, 0 = rt.
- ALUcontrol  output  4  ALU op.
- MemWrite  output  1  data memory write strobe.
- MemRead  output  1  data memory read strobe.
- MemToReg  output  1  1 = memory data to register file.
- illegal  output  1  one-cycle pulse on unsupported instruction.
- retired  output  CNT_W  count of completed legal instructions.

Behaviour:
- Reset (async, rst_n=0): state=FETCH; inst=0; all control outputs 0; illegal=0; retired=0; mem counter=0. Mid-instruction reset aborts immediately. No strobe may be high in the cycle after rst_n rises.
- FETCH:
  - inst_ready=1.
  - If inst_valid, latch inst_in into inst and go to DECODE.
  - Otherwise stay; all strobes 0.
- DECODE:
  - Register RegDst, ALUSrc, ALUcontrol and MemToReg from inst. They hold stable until the next acceptance.
  - Legal instructions:
    - R-type (op 000000), funct: 100000 add ALUcontrol=0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001; 101010 slt 0111. RegDst=1, ALUSrc=0, MemToReg=0.
    - lw (op 100011): RegDst=0, ALUSrc=1, ALUcontrol=0010, MemToReg=1.
    - sw (op 101011): RegDst=0, ALUSrc=1, ALUcontrol=0010, MemToReg=0.
  - Anything else: pulse illegal for 1 cycle, set all control outputs to 0, return to FETCH; retired is not incremented.
  - Legal instructions go to EXEC.
- EXEC (1 cycle): R-type goes to WB; lw/sw go to MEM.
- MEM:
  - Lasts exactly MEM_LAT cycles, counted by an internal counter loaded with MEM_LAT-1 on entry.
  - MemRead=1 (lw) or MemWrite=1 (sw) for every MEM cycle.
  - At count 0: lw goes to WB; sw goes to FETCH and retired increments.
- WB (1 cycle): RegWrite=1, then go to FETCH and retired increments.
- Latency with MEM_LAT=1, from acceptance edge to next inst_ready: R-type 3 cycles (DECODE, EXEC, WB); lw 4; sw 3.
- retired wraps modulo 2^CNT_W without saturation.
- Strobes (RegWrite, MemRead, MemWrite) are registered outputs, decoded from next-state, so they align with the state cycle and are glitch-free.
- inst_valid is ignored outside FETCH; upstream must hold it and inst_in until inst_ready.

Optional Feature:
- Macro: MIPS_MC_BEQ_EN.
- When defined:
  - Adds input alu_zero (1) and outputs Branch (1) and branch_taken (1).
  - beq (op 000100) is legal: ALUSrc=0, ALUcontrol=0110.
  - EXEC asserts Branch=1 for 1 cycle; branch_taken = alu_zero in that cycle.
  - Then go to FETCH; retired increments.
- When undefined: ports absent; beq is illegal.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ;
  - funct constants;
  - ALUcontrol encodings ALU_ADD/SUB/AND/OR/SLT;
  - state typedef (FETCH, DECODE, EXEC, MEM, WB).
- One sub-module, mips_alu_decode: combinational op/funct to ALUcontrol plus legal flag. It is reusable by the single-cycle datapath control.

Test Plan:
- Reset mid-MEM of lw (drop rst_n asynchronously): all outputs 0 immediately, state FETCH, inst_ready=1 after release, retired=0.
- inst_in=0x00430820 (add $1,$2,$3), valid held: RegDst=1, ALUSrc=0, ALUcontrol=0010. RegWrite high exactly in cycle 3 after acceptance. retired 0→1.
- inst_in=0x8C410000 (lw $1,0($2)) with MEM_LAT=3: MemRead high 3 consecutive cycles, then RegWrite=1 with MemToReg=1 for 1 cycle. Next inst_ready 6 cycles after acceptance.
- inst_in=0xAC410000 (sw $1,0($2)): MemWrite high 1 cycle, RegWrite never high, ALUSrc=1, ALUcontrol=0010.
- inst_in=0x08000000 (j): illegal pulses 1 cycle, no strobes, retired unchanged, back to FETCH.
- Back-to-back add/sub/and/or/slt with inst_valid held high, CNT_W=2: ALUcontrol sequence 0010, 0110, 0000, 0001, 0111. retired wraps 3→0 after the 4th instruction.
